// File: rtl/rb_write_ctrl.sv
// Row-buffer write controller: lane-rotating BRAM writes plus
// registered steering controls aligned with the 1-cycle BRAM read.
module rb_write_ctrl #(
    parameter int PIXEL_WIDTH       = 8,
    parameter int RBs               = 3,
    parameter int RB_ADDR           = 2,
    parameter int BRAM_R_DATA_WIDTH = 24,
    parameter int IMG_WIDTH         = 640,
    parameter int IMG_HEIGHT        = 480,
    parameter int COL_ADDR          = 10,
    parameter int ROW_ADDR          = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PIXEL_WIDTH-1:0]       in_pixel,
    output logic [RBs-1:0]               bram_we,
    output logic [COL_ADDR-1:0]          bram_addr,
    output logic [BRAM_R_DATA_WIDTH-1:0] bram_wdata,
    output logic                         steer_en,
    output logic [RB_ADDR-1:0]           steer_sel,
    output logic [PIXEL_WIDTH-1:0]       cur_pixel,
    output logic                         frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [COL_ADDR-1:0] col;
    logic [ROW_ADDR-1:0] row;
    logic [RB_ADDR-1:0]  wr_rb;
    logic                accept;
    logic                eol;
    logic                last_row;
    logic                fill_full;
    logic                done_nxt;

    assign accept    = in_valid & in_ready;
    assign eol       = accept && (col == COL_ADDR'(IMG_WIDTH - 1));
    assign last_row  = (row == ROW_ADDR'(IMG_HEIGHT - 1));
    assign fill_full = (row == ROW_ADDR'(RBs - 1));

    assign bram_addr  = col;
    assign bram_we    = accept ? (RBs'(1) << wr_rb) : '0;
    assign bram_wdata = {RBs{in_pixel}};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                // Last-row test first covers frames no taller than the window
                if (eol && last_row) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (eol && fill_full) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (eol && last_row) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            wr_rb <= '0;
        end else if (state == IDLE && start) begin
            col   <= '0;
            row   <= '0;
            wr_rb <= '0;
        end else if (accept) begin
            if (col == COL_ADDR'(IMG_WIDTH - 1)) begin
                col   <= '0;
                row   <= row + ROW_ADDR'(1);
                wr_rb <= (wr_rb == RB_ADDR'(RBs - 1)) ?
                         '0 : wr_rb + RB_ADDR'(1);
            end else begin
                col <= col + COL_ADDR'(1);
            end
        end
    end

    // Registered to line up with the BRAM read data of the same column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steer_en  <= 1'b0;
            steer_sel <= '0;
            cur_pixel <= '0;
        end else begin
            steer_en <= accept && (state == RUN);
            if (accept) begin
                steer_sel <= wr_rb;
                cur_pixel <= in_pixel;
            end
        end
    end

endmodule

// File: tb/tb_rb_write_ctrl.sv
// Directed bench for rb_write_ctrl on a 4x5 frame with 3 row buffers,
// with a read-first BRAM model feeding the steered-lane checks.
module tb_rb_write_ctrl;

    localparam int PW  = 8;
    localparam int RBS = 3;
    localparam int RBA = 2;
    localparam int BW  = 24;
    localparam int IW  = 4;
    localparam int IH  = 5;
    localparam int CA  = 2;
    localparam int RA  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_pixel = '0;
    logic [RBS-1:0] bram_we;
    logic [CA-1:0] bram_addr;
    logic [BW-1:0] bram_wdata;
    logic          steer_en;
    logic [RBA-1:0] steer_sel;
    logic [PW-1:0] cur_pixel;
    logic          frame_done;

    int vecs = 0;
    int miss = 0;

    logic [BW-1:0] mem [IW];
    logic [BW-1:0] rdata;
    logic [2:0]    exp_we;

    rb_write_ctrl #(
        .PIXEL_WIDTH      (PW),
        .RBs              (RBS),
        .RB_ADDR          (RBA),
        .BRAM_R_DATA_WIDTH(BW),
        .IMG_WIDTH        (IW),
        .IMG_HEIGHT       (IH),
        .COL_ADDR         (CA),
        .ROW_ADDR         (RA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_wdata(bram_wdata),
        .steer_en  (steer_en),
        .steer_sel (steer_sel),
        .cur_pixel (cur_pixel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Read-first BRAM: read data is the pre-write content
    always @(posedge clk) begin
        rdata <= mem[bram_addr];
        for (int l = 0; l < RBS; l++)
            if (bram_we[l])
                mem[bram_addr][l*PW +: PW] <= bram_wdata[l*PW +: PW];
    end

    function automatic logic [PW-1:0] lane(input int k);
        int p;
        p = (int'(steer_sel) + k) % RBS;
        return rdata[p*PW +: PW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        #2;
        vecs++;
        if ({in_ready, bram_we, bram_addr, bram_wdata, steer_en,
             steer_sel, cur_pixel, frame_done} !== '0) begin
            miss++;
            $display("FAIL reset_outputs got %h want 0",
                {in_ready, bram_we, bram_addr, bram_wdata,
                 steer_en, steer_sel, cur_pixel, frame_done});
        end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'h55;
        repeat (3) begin
            #1;
            vecs++;
            if (in_ready !== 1'b0 || bram_we !== 3'b000) begin
                miss++;
                $display("FAIL no_start ready=%b we=%b want 0/000",
                    in_ready, bram_we);
            end
            tick();
        end
        vecs++;
        if (steer_en !== 1'b0 || cur_pixel !== 8'h00 ||
            frame_done !== 1'b0) begin
            miss++;
            $display("FAIL no_start_regs en=%b cur=%h fd=%b want 0",
                steer_en, cur_pixel, frame_done);
        end
        in_valid = 1'b0;
        in_pixel = '0;
    endtask

    task automatic test_start();
        in_valid = 1'b0;
        start = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 1'b0) begin
            miss++;
            $display("FAIL idle_ready got %b want 0", in_ready);
        end
        tick();
        start = 1'b0;
        vecs++;
        if (in_ready !== 1'b1) begin
            miss++;
            $display("FAIL fill_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_fill(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            in_valid = 1'b1;
            in_pixel = 8'(i);
            #1;
            exp_we = 3'b001 << (i / IW);
            vecs++;
            if (bram_we !== exp_we || bram_addr !== CA'(i % IW) ||
                bram_wdata !== {3{8'(i)}}) begin
                miss++;
                $display("FAIL fill_write px=%0d we=%b addr=%0d wd=%h want %b/%0d",
                    i, bram_we, bram_addr, bram_wdata, exp_we, i % IW);
            end
            tick();
            vecs++;
            if (steer_en !== 1'b0 || cur_pixel !== 8'(i)) begin
                miss++;
                $display("FAIL fill_regs px=%0d en=%b cur=%h want 0/%h",
                    i, steer_en, cur_pixel, i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        in_valid = 1'b1;
        in_pixel = 8'h06;
        start = 1'b1;
        #1;
        vecs++;
        if (bram_we !== 3'b010 || bram_addr !== 2'd2 ||
            in_ready !== 1'b1) begin
            miss++;
            $display("FAIL start_ignored we=%b addr=%0d rdy=%b want 010/2/1",
                bram_we, bram_addr, in_ready);
        end
        tick();
        start = 1'b0;
        vecs++;
        if (cur_pixel !== 8'h06 || steer_en !== 1'b0) begin
            miss++;
            $display("FAIL start_ignored_regs cur=%h en=%b want 06/0",
                cur_pixel, steer_en);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_first_window();
        in_valid = 1'b1;
        in_pixel = 8'h0C;
        #1;
        vecs++;
        if (bram_we !== 3'b001 || bram_addr !== 2'd0) begin
            miss++;
            $display("FAIL row3_write we=%b addr=%0d want 001/0",
                bram_we, bram_addr);
        end
        tick();
        in_valid = 1'b0;
        vecs++;
        if (steer_en !== 1'b1 || steer_sel !== 2'd0 ||
            cur_pixel !== 8'h0C) begin
            miss++;
            $display("FAIL row3_steer en=%b sel=%0d cur=%h want 1/0/0c",
                steer_en, steer_sel, cur_pixel);
        end
        vecs++;
        if (lane(0) !== 8'h00 || lane(1) !== 8'h04 ||
            lane(2) !== 8'h08) begin
            miss++;
            $display("FAIL row3_lanes got %h %h %h want 00 04 08",
                lane(0), lane(1), lane(2));
        end
    endtask

    task automatic test_complete();
        int r, c, ln, pl;
        for (int p = 13; p < IW * IH; p++) begin
            r  = p / IW;
            c  = p % IW;
            ln = r % RBS;
            pl = ((p - 1) / IW) % RBS;
            in_valid = 1'b0;
            in_pixel = 8'hEE;
            #1;
            vecs++;
            if (bram_we !== 3'b000 || in_ready !== 1'b1 ||
                frame_done !== 1'b0) begin
                miss++;
                $display("FAIL stall_write px=%0d we=%b rdy=%b fd=%b",
                    p, bram_we, in_ready, frame_done);
            end
            tick();
            vecs++;
            if (steer_en !== 1'b0 || steer_sel !== RBA'(pl)) begin
                miss++;
                $display("FAIL stall_hold px=%0d en=%b sel=%0d want 0/%0d",
                    p, steer_en, steer_sel, pl);
            end
            in_valid = 1'b1;
            in_pixel = 8'(p);
            #1;
            exp_we = 3'b001 << ln;
            vecs++;
            if (bram_we !== exp_we || bram_addr !== CA'(c)) begin
                miss++;
                $display("FAIL run_write px=%0d we=%b addr=%0d want %b/%0d",
                    p, bram_we, bram_addr, exp_we, c);
            end
            tick();
            vecs++;
            if (steer_en !== 1'b1 || steer_sel !== RBA'(ln) ||
                cur_pixel !== 8'(p)) begin
                miss++;
                $display("FAIL run_steer px=%0d en=%b sel=%0d cur=%h want 1/%0d/%h",
                    p, steer_en, steer_sel, cur_pixel, ln, p);
            end
            for (int k = 0; k < RBS; k++) begin
                vecs++;
                if (lane(k) !== 8'((r - RBS + k) * IW + c)) begin
                    miss++;
                    $display("FAIL run_lane px=%0d k=%0d got %h want %h",
                        p, k, lane(k), (r - RBS + k) * IW + c);
                end
            end
        end
        in_valid = 1'b0;
        #1;
        vecs++;
        if (frame_done !== 1'b1 || in_ready !== 1'b0) begin
            miss++;
            $display("FAIL done_pulse fd=%b rdy=%b want 1/0",
                frame_done, in_ready);
        end
        tick();
        vecs++;
        if (frame_done !== 1'b0 || in_ready !== 1'b0 ||
            bram_we !== 3'b000) begin
            miss++;
            $display("FAIL idle_after fd=%b rdy=%b we=%b want 0/0/000",
                frame_done, in_ready, bram_we);
        end
    endtask

    task automatic test_reset_mid();
        test_start();
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_pixel = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        in_pixel = '0;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({in_ready, bram_we, bram_addr, bram_wdata, steer_en,
             steer_sel, cur_pixel, frame_done} !== '0) begin
            miss++;
            $display("FAIL midreset_outputs got %h want 0",
                {in_ready, bram_we, bram_addr, bram_wdata,
                 steer_en, steer_sel, cur_pixel, frame_done});
        end
        tick();
        rst_n = 1'b1;
        tick();
        vecs++;
        if (in_ready !== 1'b0 || frame_done !== 1'b0) begin
            miss++;
            $display("FAIL midreset_idle rdy=%b fd=%b want 0/0",
                in_ready, frame_done);
        end
        test_start();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pixel = 8'(8'hA0 + i);
            #1;
            vecs++;
            if (bram_we !== 3'b001 || bram_addr !== CA'(i)) begin
                miss++;
                $display("FAIL restart_write i=%0d we=%b addr=%0d want 001/%0d",
                    i, bram_we, bram_addr, i);
            end
            tick();
            vecs++;
            if (steer_en !== 1'b0 || cur_pixel !== 8'(8'hA0 + i)) begin
                miss++;
                $display("FAIL restart_regs i=%0d en=%b cur=%h",
                    i, steer_en, cur_pixel);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_fill(0, 5);
        test_start_ignored();
        test_fill(7, 11);
        test_first_window();
        test_complete();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
